// File: rtl/wts_channel_array.sv
// wts_channel_array
//   Time-multiplexed wave-table channel engine. CH channels share one datapath.
//   Each 'active' pulse services one channel slot: that channel's tone address
//   counter, ADSR envelope and noise gate advance by one step. The result
//   {channel, wave address, gated envelope} goes to the SRAM/mixer stage.
//
// Ports
//   clk, nreset                 clock, asynchronous active-low reset
//   active                      service strobe, one clk wide
//   key_on/key_release/key_off  per-channel event pulses, held pending until serviced
//   address_reset               per-channel pulse, wave address to 0 at next service
//   reg_*                       per-channel settings, channel n in field n of each vector
//   out_valid                   one-clk pulse after each active
//   out_channel, sram_a         serviced channel, {channel, 7-bit wave address}
//   envelope                    gated envelope level of the serviced channel
//   env_state                   envelope FSM state of the serviced channel
//
// Output handshake: there is no back-pressure. out_valid is high for exactly
// the clk after an active pulse; out_channel/sram_a/envelope/env_state change
// only on that clk and hold their values until the next one.
module wts_channel_array #(
  parameter int          CH        = 5,
  parameter logic [16:0] LFSR_SEED = 17'h1,
  localparam int         CH_W      = $clog2(CH)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              active,
  input  logic [CH-1:0]     key_on,
  input  logic [CH-1:0]     key_release,
  input  logic [CH-1:0]     key_off,
  input  logic [CH-1:0]     address_reset,
  input  logic [CH*8-1:0]   reg_ar,
  input  logic [CH*8-1:0]   reg_dr,
  input  logic [CH*8-1:0]   reg_sr,
  input  logic [CH*8-1:0]   reg_rr,
  input  logic [CH*7-1:0]   reg_sl,
  input  logic [CH*2-1:0]   reg_wave_length,
  input  logic [CH*12-1:0]  reg_frequency_count,
  input  logic [CH-1:0]     reg_noise_enable,
  input  logic [CH*5-1:0]   reg_noise_frequency_count,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_channel,
  output logic [CH_W+6:0]   sram_a,
  output logic [7:0]        envelope,
  output logic [2:0]        env_state
);

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  // Per-channel state
  logic [6:0]  addr_q  [CH];
  logic [11:0] cnt_q   [CH];
  logic [7:0]  level_q [CH];
  logic [7:0]  acc_q   [CH];
  env_state_t  st_q    [CH];
  logic [4:0]  ndiv_q  [CH];
  logic [CH-1:0] nbit_q;
  logic [CH-1:0] pend_on, pend_off, pend_rel, pend_addr;

  // Shared state
  logic [CH_W-1:0] slot;
  logic [16:0]     lfsr;

  // Next values for the serviced slot
  int unsigned     si;
  logic [CH_W-1:0] slot_next;
  logic [CH-1:0]   slot_clr;
  logic            ev_on, ev_off, ev_rel, ev_addr;
  logic [11:0]     reload;
  logic [6:0]      addr_mask;
  logic [6:0]      addr_n;
  logic [11:0]     cnt_n;
  env_state_t      st_c, st_n;
  logic [7:0]      lvl, level_n, acc_n, rate, target;
  logic [8:0]      sum;
  logic [4:0]      ndiv_n;
  logic            nbit_n;
  logic [7:0]      env_n;

  always_comb begin
    si        = int'(slot);
    slot_next = (slot == CH_W'(CH - 1)) ? '0 : slot + CH_W'(1);
    // Service clears the slot's pending bits; a pulse in the same clk re-sets them.
    slot_clr  = active ? (CH'(1) << slot) : '0;

    // Event priority: off > on > release; losers are dropped with the clear.
    ev_off  = pend_off[slot];
    ev_on   = pend_on[slot] & ~ev_off;
    ev_rel  = pend_rel[slot] & ~ev_off & ~ev_on;
    ev_addr = pend_addr[slot];

    // Tone address counter
    reload = reg_frequency_count[si*12 +: 12];
    case (reg_wave_length[si*2 +: 2])
      2'd0:    addr_mask = 7'h0f;
      2'd1:    addr_mask = 7'h1f;
      2'd2:    addr_mask = 7'h3f;
      default: addr_mask = 7'h7f;
    endcase
    addr_n = addr_q[slot];
    cnt_n  = cnt_q[slot];
    if (ev_on || ev_addr) begin
      addr_n = '0;
      cnt_n  = reload;
    end else if (cnt_q[slot] == 12'd0) begin
      cnt_n  = reload;
      addr_n = (addr_q[slot] + 7'd1) & addr_mask;
    end else begin
      cnt_n  = cnt_q[slot] - 12'd1;
    end

    // Envelope FSM: a step happens when acc + rate carries out of 8 bits.
    st_c   = st_q[slot];
    lvl    = level_q[slot];
    target = {reg_sl[si*7 +: 7], 1'b0};
    case (st_c)
      ENV_ATTACK:  rate = reg_ar[si*8 +: 8];
      ENV_DECAY:   rate = reg_dr[si*8 +: 8];
      ENV_SUSTAIN: rate = reg_sr[si*8 +: 8];
      ENV_RELEASE: rate = reg_rr[si*8 +: 8];
      default:     rate = 8'd0;
    endcase
    sum     = {1'b0, acc_q[slot]} + {1'b0, rate};
    st_n    = st_c;
    level_n = lvl;
    acc_n   = acc_q[slot];
    if (ev_off) begin
      st_n    = ENV_IDLE;
      level_n = '0;
      acc_n   = '0;
    end else if (ev_on) begin
      st_n    = ENV_ATTACK;
      level_n = '0;
      acc_n   = '0;
    end else if (ev_rel && st_c != ENV_IDLE) begin
      st_n = ENV_RELEASE;
    end else begin
      acc_n = sum[7:0];
      case (st_c)
        ENV_ATTACK: begin
          if (sum[8] && lvl != 8'hff) level_n = lvl + 8'd1;
          if (level_n == 8'hff) st_n = ENV_DECAY;
        end
        ENV_DECAY: begin
          // Compare in 9 bits so level 0 with target 0 cannot wrap.
          if (sum[8]) begin
            if ({1'b0, lvl} <= {1'b0, target} + 9'd1) begin
              level_n = target;
              st_n    = ENV_SUSTAIN;
            end else begin
              level_n = lvl - 8'd1;
            end
          end
        end
        ENV_SUSTAIN: begin
          if (sum[8] && lvl != 8'd0) level_n = lvl - 8'd1;
        end
        ENV_RELEASE: begin
          if (sum[8]) begin
            if (lvl <= 8'd1) begin
              level_n = '0;
              st_n    = ENV_IDLE;
            end else begin
              level_n = lvl - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end

    // Noise gate samples the shared LFSR before this service advances it.
    if (ndiv_q[slot] == 5'd0) begin
      ndiv_n = reg_noise_frequency_count[si*5 +: 5];
      nbit_n = lfsr[0];
    end else begin
      ndiv_n = ndiv_q[slot] - 5'd1;
      nbit_n = nbit_q[slot];
    end
    env_n = (!reg_noise_enable[slot] || nbit_n) ? level_n : 8'd0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot        <= '0;
      lfsr        <= LFSR_SEED;
      pend_on     <= '0;
      pend_off    <= '0;
      pend_rel    <= '0;
      pend_addr   <= '0;
      nbit_q      <= '0;
      out_valid   <= 1'b0;
      out_channel <= '0;
      sram_a      <= '0;
      envelope    <= '0;
      env_state   <= '0;
      for (int i = 0; i < CH; i++) begin
        addr_q[i]  <= '0;
        cnt_q[i]   <= '0;
        level_q[i] <= '0;
        acc_q[i]   <= '0;
        st_q[i]    <= ENV_IDLE;
        ndiv_q[i]  <= '0;
      end
    end else begin
      pend_on   <= (pend_on   & ~slot_clr) | key_on;
      pend_off  <= (pend_off  & ~slot_clr) | key_off;
      pend_rel  <= (pend_rel  & ~slot_clr) | key_release;
      pend_addr <= (pend_addr & ~slot_clr) | address_reset;
      out_valid <= active;
      if (active) begin
        slot          <= slot_next;
        lfsr          <= {lfsr[15:0], lfsr[16] ^ lfsr[13]};
        addr_q[slot]  <= addr_n;
        cnt_q[slot]   <= cnt_n;
        level_q[slot] <= level_n;
        acc_q[slot]   <= acc_n;
        st_q[slot]    <= st_n;
        ndiv_q[slot]  <= ndiv_n;
        nbit_q[slot]  <= nbit_n;
        out_channel   <= slot;
        sram_a        <= {slot, addr_n};
        envelope      <= env_n;
        env_state     <= st_n;
      end
    end
  end

endmodule

// File: tb/tb_wts_channel_array.sv
// Testbench for wts_channel_array: randomized and directed stimulus checked
// against a behavioural channel model.
module tb_wts_channel_array;
  localparam int CH   = 5;
  localparam int CH_W = 3;
  localparam int W    = 2 * CH_W + 15;
  localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic active = 1'b0;
  logic [CH-1:0]    key_on = '0, key_release = '0, key_off = '0, address_reset = '0;
  logic [CH*8-1:0]  reg_ar = '0, reg_dr = '0, reg_sr = '0, reg_rr = '0;
  logic [CH*7-1:0]  reg_sl = '0;
  logic [CH*2-1:0]  reg_wave_length = '0;
  logic [CH*12-1:0] reg_frequency_count = '0;
  logic [CH-1:0]    reg_noise_enable = '0;
  logic [CH*5-1:0]  reg_noise_frequency_count = '0;
  logic             out_valid;
  logic [CH_W-1:0]  out_channel;
  logic [CH_W+6:0]  sram_a;
  logic [7:0]       envelope;
  logic [2:0]       env_state;

  always #5 clk = ~clk;

  wts_channel_array #(.CH(CH), .LFSR_SEED(17'h1)) dut (
    .clk(clk), .nreset(nreset), .active(active),
    .key_on(key_on), .key_release(key_release), .key_off(key_off),
    .address_reset(address_reset),
    .reg_ar(reg_ar), .reg_dr(reg_dr), .reg_sr(reg_sr), .reg_rr(reg_rr),
    .reg_sl(reg_sl), .reg_wave_length(reg_wave_length),
    .reg_frequency_count(reg_frequency_count),
    .reg_noise_enable(reg_noise_enable),
    .reg_noise_frequency_count(reg_noise_frequency_count),
    .out_valid(out_valid), .out_channel(out_channel), .sram_a(sram_a),
    .envelope(envelope), .env_state(env_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  int last_env[CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_slot, m_lfsr;
  int m_addr[CH], m_cnt[CH], m_level[CH], m_acc[CH], m_phase[CH], m_div[CH], m_nb[CH];
  bit m_pon[CH], m_poff[CH], m_prel[CH], m_par[CH];

  task automatic model_reset();
    m_slot = 0;
    m_lfsr = 1;
    for (int c = 0; c < CH; c++) begin
      m_addr[c] = 0; m_cnt[c] = 0; m_level[c] = 0; m_acc[c] = 0;
      m_phase[c] = P_IDLE; m_div[c] = 0; m_nb[c] = 0;
      m_pon[c] = 0; m_poff[c] = 0; m_prel[c] = 0; m_par[c] = 0;
      last_env[c] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_edge(input bit act, input logic [CH-1:0] kon, krel, koff, kar);
    int s, len, rate, total, target, env, fb;
    bit off, on, rel, stepped;
    if (act) begin
      s   = m_slot;
      off = m_poff[s];
      on  = m_pon[s] && !off;
      rel = m_prel[s] && !off && !on;
      // tone
      len = 16 << reg_wave_length[s*2 +: 2];
      if (on || m_par[s]) begin
        m_addr[s] = 0;
        m_cnt[s]  = int'(reg_frequency_count[s*12 +: 12]);
      end else if (m_cnt[s] == 0) begin
        m_cnt[s]  = int'(reg_frequency_count[s*12 +: 12]);
        m_addr[s] = (m_addr[s] + 1) % len;
      end else begin
        m_cnt[s] = m_cnt[s] - 1;
      end
      // envelope
      if (off) begin
        m_phase[s] = P_IDLE; m_level[s] = 0; m_acc[s] = 0;
      end else if (on) begin
        m_phase[s] = P_ATT; m_level[s] = 0; m_acc[s] = 0;
      end else if (rel && m_phase[s] != P_IDLE) begin
        m_phase[s] = P_REL;
      end else begin
        case (m_phase[s])
          P_ATT:   rate = int'(reg_ar[s*8 +: 8]);
          P_DEC:   rate = int'(reg_dr[s*8 +: 8]);
          P_SUS:   rate = int'(reg_sr[s*8 +: 8]);
          P_REL:   rate = int'(reg_rr[s*8 +: 8]);
          default: rate = 0;
        endcase
        total     = m_acc[s] + rate;
        stepped   = (total >= 256);
        m_acc[s]  = total % 256;
        if (stepped) begin
          case (m_phase[s])
            P_ATT: begin
              m_level[s] = m_level[s] + 1;
              if (m_level[s] >= 255) begin m_level[s] = 255; m_phase[s] = P_DEC; end
            end
            P_DEC: begin
              target = 2 * int'(reg_sl[s*7 +: 7]);
              if (m_level[s] - 1 <= target) begin m_level[s] = target; m_phase[s] = P_SUS; end
              else m_level[s] = m_level[s] - 1;
            end
            P_SUS: if (m_level[s] > 0) m_level[s] = m_level[s] - 1;
            P_REL: begin
              if (m_level[s] > 0) m_level[s] = m_level[s] - 1;
              if (m_level[s] == 0) m_phase[s] = P_IDLE;
            end
            default: ;
          endcase
        end
      end
      // noise
      if (m_div[s] == 0) begin
        m_div[s] = int'(reg_noise_frequency_count[s*5 +: 5]);
        m_nb[s]  = m_lfsr & 1;
      end else begin
        m_div[s] = m_div[s] - 1;
      end
      env = (!reg_noise_enable[s] || m_nb[s] != 0) ? m_level[s] : 0;
      exp_q.push_back({CH_W'(s), CH_W'(s), 7'(m_addr[s]), 8'(env)});
      m_pon[s] = 0; m_poff[s] = 0; m_prel[s] = 0; m_par[s] = 0;
      m_slot = (s + 1) % CH;
      fb     = ((m_lfsr >> 16) ^ (m_lfsr >> 13)) & 1;
      m_lfsr = ((m_lfsr << 1) | fb) & 32'h1ffff;
    end
    for (int c = 0; c < CH; c++) begin
      m_pon[c]  = m_pon[c]  | kon[c];
      m_prel[c] = m_prel[c] | krel[c];
      m_poff[c] = m_poff[c] | koff[c];
      m_par[c]  = m_par[c]  | kar[c];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit act, input logic [CH-1:0] kon, krel, koff, kar);
    logic [W-1:0] e;
    int ch;
    active = act; key_on = kon; key_release = krel; key_off = koff; address_reset = kar;
    @(posedge clk);
    model_edge(act, kon, krel, koff, kar);
    #1;
    active = 1'b0; key_on = '0; key_release = '0; key_off = '0; address_reset = '0;
    if (act) begin
      e  = exp_q.pop_front();
      ch = int'(e[W-1 -: CH_W]);
      check_eq("valid", 32'(out_valid), 32'd1);
      check_eq($sformatf("channel_ch%0d", ch), 32'(out_channel), 32'(e[W-1 -: CH_W]));
      check_eq($sformatf("sram_a_ch%0d", ch), 32'(sram_a), 32'(e[W-CH_W-1 -: CH_W+7]));
      check_eq($sformatf("envelope_ch%0d", ch), 32'(envelope), 32'(e[7:0]));
      last_env[ch] = int'(envelope);
    end else begin
      check_eq("valid_idle", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic svc();
    drive(1'b1, '0, '0, '0, '0);
  endtask

  task automatic gap(input logic [CH-1:0] kon, krel, koff, kar);
    drive(1'b0, kon, krel, koff, kar);
  endtask

  function automatic logic [CH-1:0] rk(input int n);
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = ($urandom_range(0, n - 1) == 0);
    return v;
  endfunction

  function automatic logic [7:0] pick_rate();
    case ($urandom_range(0, 5))
      0:       return 8'd0;
      1:       return 8'd255;
      default: return 8'($urandom_range(1, 254));
    endcase
  endfunction

  task automatic randomize_regs();
    for (int c = 0; c < CH; c++) begin
      reg_ar[c*8 +: 8] = pick_rate();
      reg_dr[c*8 +: 8] = pick_rate();
      reg_sr[c*8 +: 8] = pick_rate();
      reg_rr[c*8 +: 8] = pick_rate();
      reg_sl[c*7 +: 7] = 7'($urandom_range(0, 127));
      reg_wave_length[c*2 +: 2] = 2'($urandom_range(0, 3));
      reg_frequency_count[c*12 +: 12] = 12'($urandom_range(0, 5));
      reg_noise_enable[c] = 1'($urandom_range(0, 1));
      reg_noise_frequency_count[c*5 +: 5] = 5'($urandom_range(0, 3));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_channel"}, 32'(out_channel), 32'd0);
    check_eq({tag, "_sram_a"}, 32'(sram_a), 32'd0);
    check_eq({tag, "_envelope"}, 32'(envelope), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    nreset = 1'b1;

    // ch2: full attack, decay to sl*2, hold in sustain; tone freq 2, 16-entry wave
    reg_ar[2*8 +: 8] = 8'd255;
    reg_dr[2*8 +: 8] = 8'd128;
    reg_sl[2*7 +: 7] = 7'h20;
    reg_frequency_count[2*12 +: 12] = 12'd2;
    gap(5'b00100, '0, '0, '0);
    for (int i = 0; i < 760 * CH; i++) begin
      svc();
      if ($urandom_range(0, 1) == 1) gap('0, '0, '0, '0);
    end
    check_eq("ch2_sustain_level", 32'(last_env[2]), 32'd64);

    // ch1: rise, then key_on and key_off in the same clk, then release while idle
    reg_ar[1*8 +: 8] = 8'd255;
    gap(5'b00010, '0, '0, '0);
    repeat (4 * CH) svc();
    gap(5'b00010, '0, 5'b00010, '0);
    repeat (2 * CH) svc();
    check_eq("ch1_on_off_level", 32'(last_env[1]), 32'd0);
    gap('0, 5'b00010, '0, '0);
    repeat (2 * CH) svc();
    check_eq("ch1_release_idle_level", 32'(last_env[1]), 32'd0);

    // ch3: key_on lands in the clk that services ch3
    reg_ar[3*8 +: 8] = 8'd255;
    while (m_slot != 3) svc();
    drive(1'b1, 5'b01000, '0, '0, '0);
    repeat (4 * CH) svc();

    // address_reset on ch2 mid-run
    gap('0, '0, '0, 5'b00100);
    repeat (2 * CH) svc();

    // randomized traffic, noise enabled on some channels
    for (int i = 0; i < 2500; i++) begin
      if (i % 250 == 0) randomize_regs();
      drive(1'b1, rk(20), rk(40), rk(60), rk(30));
      if ($urandom_range(0, 2) == 0) gap(rk(20), rk(40), rk(60), rk(30));
    end

    // reset in the middle of an attack, with events pending
    for (int c = 0; c < CH; c++) reg_ar[c*8 +: 8] = 8'd255;
    gap('1, '0, '0, '0);
    repeat (8 * CH) svc();
    gap('1, '0, '0, '1);
    #2 nreset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    nreset = 1'b1;
    model_reset();
    repeat (6 * CH) svc();
    for (int c = 0; c < CH; c++) check_eq($sformatf("post_reset_ch%0d", c), 32'(last_env[c]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
